// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin packet-atomic arbiter for a shared fifo write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
  input  logic                          i_fifo_full,
  output logic [ID_WIDTH-1:0]           o_grant_id,
  output logic                          o_busy,
  output logic                          o_timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [ID_WIDTH:0]   N       = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ-1);
  localparam logic [7:0]          TO_LAST = 8'(TIMEOUT-1);
  state_t state;
  logic [ID_WIDTH-1:0] ptr, pick, nxt;
  logic [ID_WIDTH:0] off, sum;
  logic [2*NUM_REQ-1:0] dbl;
  logic [7:0] cnt;
  logic act, xfer;
  logic [DATA_WIDTH-1:0] beats [NUM_REQ];
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_beat
    assign beats[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
  end
  // rotate valids so bit 0 is the pointer position; lowest set bit wins
  assign dbl = {i_req_valid, i_req_valid} >> ptr;
  always_comb begin
    off = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) if (dbl[i]) off = (ID_WIDTH+1)'(i);
  end
  assign sum  = {1'b0, ptr} + off;
  assign pick = ID_WIDTH'(sum >= N ? sum - N : sum);
  assign nxt  = o_grant_id == LAST_ID ? '0 : o_grant_id + 1'b1;
  // reset cycle must neither accept nor write a beat
  assign act            = state == GRANT && !i_fifo_full && !i_rst;
  assign xfer           = act && i_req_valid[o_grant_id];
  assign o_req_ready    = act ? NUM_REQ'(1) << o_grant_id : '0;
  assign o_fifo_wr_en   = xfer;
  assign o_fifo_wr_data = xfer ? beats[o_grant_id] : '0;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      o_busy     <= 1'b0;
      o_grant_id <= '0;
      o_timeout  <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      if (state == IDLE) begin
        if (|i_req_valid) begin
          state      <= GRANT;
          o_busy     <= 1'b1;
          o_grant_id <= pick;
        end
      end else if (xfer) begin
        cnt <= '0;
        if (i_req_last[o_grant_id]) begin
          state  <= IDLE;
          o_busy <= 1'b0;
          ptr    <= nxt;
        end
      end else if (cnt == TO_LAST) begin
        state     <= IDLE;
        o_busy    <= 1'b0;
        ptr       <= nxt;
        cnt       <= '0;
        o_timeout <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
